if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Instruction-fetch front end for the 5-stage pipelined CPU; sits directly upstream of decode (instrD).
//  Issues word fetches to instruction memory over a request/grant port and accepts in-order responses.
//  Buffers fetched words with their PCs in a small FIFO and presents them to decode via valid/ready.
//  Handles branch/jump redirects: flushes the queue and discards stale in-flight responses.
// PARAMETERS
//  DEPTH     4             max words buffered plus outstanding (power of 2, >=2)
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clock        in   1   system clock, rising edge
//  start        in   1   async active-low reset (0 = reset, 1 = run)
//  i_addr       out  32  fetch address to instruction memory
//  i_req        out  1   fetch request valid
//  i_gnt        in   1   memory accepts request this cycle (i_req & i_gnt = accept)
//  i_rvalid     in   1   response word valid; responses return in request order
//  i_datain     in   32  response instruction word
//  redirect     in   1   branch/jump taken; 1-cycle pulse from execute
//  redirect_pc  in   32  new fetch target, word aligned
//  instr_valid  out  1   instr_out/instr_pc valid toward decode
//  instr_out    out  32  instruction at FIFO head (feeds instrD)
//  instr_pc     out  32  PC of instr_out
//  instr_ready  in   1   decode accepts (low = hazard stall)
// BEHAVIOUR
//  Reset (start=0, async): i_req=0, i_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0,
//   FIFO, outstanding and drop counters cleared, state=FETCH. Reset mid-transfer takes effect without a clock edge.
//  State FETCH: i_req=1 iff (fifo_count + outstanding) < DEPTH. On accept: i_addr += 4, outstanding++.
//   While i_req=1 and i_gnt=0, i_addr must stay stable.
//  Response (i_rvalid=1, drop_cnt=0): push {resp_pc, i_datain}; resp_pc += 4; outstanding--.
//   resp_pc tracks the PC of the next expected response; it loads RESET_PC / redirect_pc with i_addr.
//  Latency: word pushed at edge N is visible on instr_out with instr_valid=1 after edge N (no bypass).
//  Pop when instr_valid & instr_ready; same-cycle push and pop is legal; count unchanged.
//  Credit rule guarantees no push into a full FIFO. i_rvalid with outstanding=0 is a protocol error; ignore it.
//  Head outputs are driven from FIFO storage; instr_out/instr_pc hold while instr_valid & !instr_ready.
//  Redirect (highest priority, overrides same-cycle push/pop/accept):
//   FIFO cleared (instr_valid=0 next cycle); i_addr=resp_pc=redirect_pc next cycle;
//   drop_cnt = outstanding (+1 if a request is accepted the same cycle; -1 if a response arrives the same cycle).
//   Next state = FLUSH if drop_cnt != 0, else FETCH.
//  State FLUSH: i_req=0; each i_rvalid decrements drop_cnt, data discarded; FETCH when drop_cnt reaches 0.
//   A redirect during FLUSH reloads i_addr/resp_pc; drop_cnt is unchanged (no new requests were issued).
//  Redirect while i_req=1 and i_gnt=0: request withdrawn; new address presented next cycle.
//  PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
// TESTING
//  1 start=0 -> i_req=0, instr_valid=0, i_addr=0; start=1 -> i_req=1, i_addr=0 at first edge.
//  2 i_gnt=1, 1-cycle responses 32'h8C01_0001, 32'h8C02_0002, 32'h0022_1820, ready=1
//    -> instr_out streams these words with instr_pc=0,4,8, one per cycle, each one cycle after i_rvalid.
//  3 instr_ready=0 -> after 4 accepts i_req=0; instr_out stays 32'h8C01_0001;
//    ready=1 -> one pop per cycle, i_req reasserts.
//  4 Two outstanding, redirect_pc=32'h40 -> instr_valid=0 next cycle; next 2 responses dropped;
//    i_req resumes at 0x40; first instr_pc=0x40.
//  5 Redirect in same cycle as an accept with 2 already outstanding -> 3 responses dropped.
//    Redirect same cycle as a response with 2 outstanding -> 1 dropped.
//  6 start pulsed low mid-stream between clock edges -> outputs reset immediately;
//    fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bus bundle: instruction-memory request/response port plus the decode-facing queue head.
// Handshakes: a request transfers when i_req & i_gnt; a head word transfers when instr_valid & instr_ready.
// Responses (i_rvalid) return in request order and cannot be back-pressured.
interface if_prefetch_queue_if;
    logic [31:0] i_addr;
    logic        i_req;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_datain;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output i_addr, i_req, instr_valid, instr_out, instr_pc,
        input  i_gnt, i_rvalid, i_datain, instr_ready
    );

    modport slave (
        input  i_addr, i_req, instr_valid, instr_out, instr_pc,
        output i_gnt, i_rvalid, i_datain, instr_ready
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: credit-limited fetch issue, in-order response capture into a
// PC-tagged FIFO feeding decode, and redirect handling that flushes the queue and drops stale responses.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clock,
    input  logic                       start,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    if_prefetch_queue_if.master        bus,
    output logic                       state_dbg
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {FETCH = 1'b0, FLUSH = 1'b1} state_e;

    state_e        state, state_nx;
    logic          running;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, outstanding, drop_cnt;
    logic [CW:0]   in_use;
    logic [CW-1:0] inflight_nx;
    logic          accept, resp, push, pop;

    // Buffered words plus in-flight requests never exceed DEPTH, so a response always has a free slot.
    assign in_use      = {1'b0, count} + {1'b0, outstanding};
    assign bus.i_req   = running && (state == FETCH) && (in_use < (CW+1)'(DEPTH));
    assign bus.i_addr  = fetch_pc;
    assign accept      = bus.i_req && bus.i_gnt;
    assign resp        = bus.i_rvalid && (outstanding != '0);
    assign push        = resp && (drop_cnt == '0) && !redirect;
    assign pop         = bus.instr_valid && bus.instr_ready && !redirect;
    assign inflight_nx = outstanding + CW'(accept) - CW'(resp);

    assign bus.instr_valid = (count != '0);
    assign bus.instr_out   = data_mem[rd_ptr];
    assign bus.instr_pc    = pc_mem[rd_ptr];
    assign state_dbg       = (state == FLUSH);

    always_ff @(posedge clock or negedge start) begin
        if (!start) state <= FETCH;
        else        state <= state_nx;
    end

    // Every request still in flight at a redirect belongs to the old path and must be discarded.
    always_comb begin
        state_nx = state;
        if (redirect) begin
            state_nx = (inflight_nx != '0) ? FLUSH : FETCH;
        end else begin
            case (state)
                FETCH:   state_nx = FETCH;
                FLUSH:   if (resp && drop_cnt == CW'(1)) state_nx = FETCH;
                default: state_nx = FETCH;
            endcase
        end
    end

    always_ff @(posedge clock or negedge start) begin
        if (!start) begin
            running     <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            running     <= 1'b1;
            outstanding <= inflight_nx;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                drop_cnt <= inflight_nx;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (push)   resp_pc  <= resp_pc + 32'd4;
                if (push)   wr_ptr   <= wr_ptr + AW'(1);
                if (pop)    rd_ptr   <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (resp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // Storage is cleared on reset so the head outputs read zero until the first word lands.
    always_ff @(posedge clock or negedge start) begin
        if (!start) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= bus.i_datain;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue: a memory responder plus a queue-level reference model of
// which fetch PCs should reach decode, checked every cycle, with directed redirect/reset scenarios.
module tb_if_prefetch_queue;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        start = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        state_dbg;

    if_prefetch_queue_if bus();

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .start       (start),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] exp_q[$];       // PCs delivered to the queue, oldest first
    logic [31:0] pend_pc[$];     // requests accepted by memory, not yet answered
    bit          pend_stale[$];  // answer belongs to a path abandoned by a redirect
    logic [31:0] next_pc;
    bit          running_m;
    int          n_total = 0;
    int          n_bad   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        case (pc)
            32'h0:   return 32'h8C01_0001;
            32'h4:   return 32'h8C02_0002;
            32'h8:   return 32'h0022_1820;
            default: return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    function automatic bit any_stale();
        foreach (pend_stale[i]) if (pend_stale[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit req_exp();
        return running_m && !any_stale() && ((exp_q.size() + pend_pc.size()) < DEPTH);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pend_pc.delete();
        pend_stale.delete();
        next_pc   = 32'h0;
        running_m = 1'b0;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("i_req", 32'(bus.i_req), 32'(req_exp()));
        if (req_exp()) check_val("i_addr", bus.i_addr, next_pc);
        check_val("flushing", 32'(state_dbg), 32'(any_stale()));
        check_val("instr_valid", 32'(bus.instr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_val("instr_pc", bus.instr_pc, exp_q[0]);
            check_val("instr_out", bus.instr_out, mem_word(exp_q[0]));
        end
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_i_req"}, 32'(bus.i_req), 32'd0);
        check_val({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
        check_val({tag, "_i_addr"}, bus.i_addr, 32'h0);
        check_val({tag, "_instr_out"}, bus.instr_out, 32'h0);
        check_val({tag, "_instr_pc"}, bus.instr_pc, 32'h0);
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive inputs, advance the model across the edge, then check outputs.
    task automatic step(input bit g, input bit rv, input bit rdy, input bit rd, input logic [31:0] rpc);
        bit          acc, rsp, pp, rstale;
        logic [31:0] rpc_pc;
        rsp = rv && (pend_pc.size() != 0);
        bus.i_gnt       = g;
        bus.i_rvalid    = rv;
        bus.i_datain    = rsp ? mem_word(pend_pc[0]) : $urandom();
        bus.instr_ready = rdy;
        redirect        = rd;
        redirect_pc     = rpc;
        acc = req_exp() && g;
        pp  = (exp_q.size() != 0) && rdy && !rd;
        @(posedge clock);
        running_m = 1'b1;
        if (pp) void'(exp_q.pop_front());
        if (rsp) begin
            rpc_pc = pend_pc.pop_front();
            rstale = pend_stale.pop_front();
            if (!rstale && !rd) exp_q.push_back(rpc_pc);
        end
        if (acc) begin
            pend_pc.push_back(next_pc);
            pend_stale.push_back(1'b0);
            next_pc = next_pc + 32'd4;
        end
        if (rd) begin
            exp_q.delete();
            foreach (pend_stale[i]) pend_stale[i] = 1'b1;
            next_pc = rpc;
        end
        #1;
        check_outputs();
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (pend_pc.size() == 0 && exp_q.size() == 0) break;
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        end
    endtask

    task automatic run_random(input int n, input int pg, input int prv, input int prdy, input int prd);
        logic [31:0] rpc;
        for (int i = 0; i < n; i++) begin
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 255)) << 2);
            step($urandom_range(0, 99) < pg, $urandom_range(0, 99) < prv,
                 $urandom_range(0, 99) < prdy, $urandom_range(0, 99) < prd, rpc);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.i_gnt       = 1'b0;
        bus.i_rvalid    = 1'b0;
        bus.i_datain    = 32'h0;
        bus.instr_ready = 1'b0;
        model_reset();

        #3;
        check_reset("reset");
        #9 start = 1'b1;

        // first edge after release: fetch of RESET_PC is requested
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

        // streaming with single-cycle responses
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // decode stall fills the credit window, then releases
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // redirect with two outstanding
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // redirect coinciding with an accept: three to drop
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h80);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // redirect coinciding with a response: one to drop
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hC0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // PC wrap past the top of the address space
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // randomized traffic in a few regimes
        run_random(1500, 70, 60, 70, 3);
        run_random(800, 100, 100, 30, 2);
        run_random(800, 40, 30, 90, 8);

        // asynchronous reset between clock edges
        #2 start = 1'b0;
        #1 check_reset("async_reset");
        model_reset();
        redirect = 1'b0;
        @(posedge clock);
        #1 check_reset("held_reset");
        #4 start = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        run_random(300, 80, 60, 70, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
